// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use, mul/div and branch-squash hazard control with a one-entry MD scoreboard.
// Optional HAZARD_PERF_EN adds a saturating stall-cycle counter output stall_cnt.
module hazard_stall_unit #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = $clog2(MD_LAT)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       ifid_regwrite,
    input  logic [4:0] ifid_rd,
    input  logic       ifid_is_md,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic       idex_md_start,
    input  logic [4:0] idex_md_rd,
    input  logic       branch_taken_mem,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_flush,
    output logic       md_busy,
    output logic       md_done,
    output logic [4:0] md_wb_rd
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    logic [CNT_W-1:0] count;
    logic             issue;
    logic             load_use;
    logic             md_stall;
    logic             stall;
    logic [4:0]       r;

    // An issue arriving while busy is ignored, so it never retargets the scoreboard.
    always_comb begin
        issue    = idex_md_start && !branch_taken_mem && !md_busy;
        r        = md_busy ? md_wb_rd : (issue ? idex_md_rd : 5'd0);
        load_use = idex_memread && idex_rt != 5'd0 &&
                   (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
        md_stall = (r != 5'd0 && (r == ifid_rs || (ifid_uses_rt && r == ifid_rt) ||
                   (ifid_regwrite && r == ifid_rd))) || (ifid_is_md && (md_busy || issue));
        stall       = load_use || md_stall;
        pc_write    = rst_i ? 1'b0 : (branch_taken_mem || !stall);
        ifid_write  = rst_i ? 1'b0 : (branch_taken_mem || !stall);
        ifid_flush  = rst_i || branch_taken_mem;
        idex_bubble = rst_i || branch_taken_mem || stall;
        exmem_flush = rst_i || branch_taken_mem;
        md_done     = !rst_i && md_busy && count == '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            md_busy  <= 1'b0;
            md_wb_rd <= 5'd0;
            count    <= '0;
        end else if (issue) begin
            md_busy  <= 1'b1;
            md_wb_rd <= idex_md_rd;
            count    <= CNT_W'(MD_LAT - 1);
        end else if (md_busy) begin
            if (count == '0)
                md_busy <= 1'b0;
            else
                count <= count - CNT_W'(1);
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt <= 32'd0;
        else if (!pc_write && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of hazard_stall_unit with MD_LAT=4.
module tb_hazard_stall_unit;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] ifid_rs, ifid_rt, ifid_rd, idex_rt, idex_md_rd;
    logic       ifid_uses_rt, ifid_regwrite, ifid_is_md;
    logic       idex_memread, idex_md_start, branch_taken_mem;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
    logic       md_busy, md_done;
    logic [4:0] md_wb_rd;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(.MD_LAT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .ifid_regwrite(ifid_regwrite), .ifid_rd(ifid_rd), .ifid_is_md(ifid_is_md),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .idex_md_start(idex_md_start), .idex_md_rd(idex_md_rd),
        .branch_taken_mem(branch_taken_mem),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
        .md_busy(md_busy), .md_done(md_done), .md_wb_rd(md_wb_rd)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        ifid_rs = 0; ifid_rt = 0; ifid_rd = 0; idex_rt = 0; idex_md_rd = 0;
        ifid_uses_rt = 0; ifid_regwrite = 0; ifid_is_md = 0;
        idex_memread = 0; idex_md_start = 0; branch_taken_mem = 0;
        #1;
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ifid_write", ifid_write, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_bubble", idex_bubble, 1);
        chk("rst_exmem_flush", exmem_flush, 1);
        tick; tick;
        rst_i = 1'b0;
        #1;
        chk("reset_md_busy", md_busy, 0);
        chk("reset_md_done", md_done, 0);
        chk("reset_md_wb_rd", md_wb_rd, 0);
        chk("idle_pc_write", pc_write, 1);
        chk("idle_idex_bubble", idex_bubble, 0);

        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_idex_bubble", idex_bubble, 1);
        chk("lu_ifid_flush", ifid_flush, 0);
        chk("lu_exmem_flush", exmem_flush, 0);
        ifid_rs = 1; ifid_rt = 5; ifid_uses_rt = 0;
        #1;
        chk("lu_rt_unused", pc_write, 1);
        ifid_uses_rt = 1;
        #1;
        chk("lu_rt_used", pc_write, 0);
        tick;
        idex_memread = 0; ifid_uses_rt = 0;
        #1;
        chk("lu_release", pc_write, 1);

        idex_memread = 1; idex_rt = 0; ifid_rs = 0;
        #1;
        chk("lu_r0_pc_write", pc_write, 1);
        chk("lu_r0_bubble", idex_bubble, 0);
        idex_memread = 0;

        idex_md_start = 1; idex_md_rd = 8; ifid_rs = 8;
        #1;
        chk("md_issue_stall", pc_write, 0);
        chk("md_issue_bubble", idex_bubble, 1);
        chk("md_issue_busy", md_busy, 0);
        tick;
        idex_md_start = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("md_busy", md_busy, 1);
            chk("md_wb_rd", md_wb_rd, 8);
            chk("md_done", md_done, (i == 3) ? 1 : 0);
            chk("md_dep_stall", pc_write, 0);
            tick;
        end
        chk("md_after_busy", md_busy, 0);
        chk("md_after_done", md_done, 0);
        chk("md_after_release", pc_write, 1);

        branch_taken_mem = 1; idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        idex_md_start = 1; idex_md_rd = 9;
        #1;
        chk("fl_ifid_flush", ifid_flush, 1);
        chk("fl_idex_bubble", idex_bubble, 1);
        chk("fl_exmem_flush", exmem_flush, 1);
        chk("fl_pc_write", pc_write, 1);
        chk("fl_ifid_write", ifid_write, 1);
        tick;
        branch_taken_mem = 0; idex_memread = 0; idex_md_start = 0;
        #1;
        chk("fl_squash_busy", md_busy, 0);
        chk("fl_after_pc_write", pc_write, 1);

        ifid_rs = 1; ifid_rt = 2; idex_md_start = 1; idex_md_rd = 8;
        #1;
        chk("st_issue_nodep", pc_write, 1);
        ifid_is_md = 1;
        #1;
        chk("st_issue_struct", pc_write, 0);
        tick;
        idex_md_start = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("st_struct_stall", pc_write, 0);
            chk("st_done", md_done, (i == 3) ? 1 : 0);
            tick;
        end
        chk("st_release", pc_write, 1);
        chk("st_busy_clear", md_busy, 0);
        ifid_is_md = 0;

        idex_md_start = 1; idex_md_rd = 8; ifid_regwrite = 1; ifid_rd = 8;
        #1;
        chk("waw_issue", pc_write, 0);
        tick;
        idex_md_start = 0;
        #1;
        chk("waw_busy", pc_write, 0);
        chk("waw_wb_rd", md_wb_rd, 8);
        ifid_regwrite = 0; ifid_uses_rt = 1; ifid_rt = 8;
        #1;
        chk("raw_rt", pc_write, 1'b0);
        ifid_uses_rt = 0;
        #1;
        chk("unrelated_busy", pc_write, 1);
        tick; tick; tick;
        chk("waw_done", md_done, 1);
        tick;
        chk("waw_clear", md_busy, 0);

        idex_md_start = 1; idex_md_rd = 0; ifid_rs = 0; ifid_rt = 0;
        ifid_uses_rt = 1; ifid_regwrite = 1; ifid_rd = 0;
        #1;
        chk("r0_issue", pc_write, 1);
        tick;
        idex_md_start = 0;
        #1;
        chk("r0_busy", md_busy, 1);
        chk("r0_nostall", pc_write, 1);
        tick; tick; tick; tick;
        chk("r0_clear", md_busy, 0);
        ifid_uses_rt = 0; ifid_regwrite = 0;

        idex_md_start = 1; idex_md_rd = 3;
        tick;
        idex_md_start = 0;
        tick;
        chk("mid_busy", md_busy, 1);
        chk("mid_done", md_done, 0);
        rst_i = 1;
        #1;
        chk("mid_rst_pc_write", pc_write, 0);
        chk("mid_rst_flush", ifid_flush, 1);
        chk("mid_rst_done", md_done, 0);
        tick;
        rst_i = 0;
        #1;
        chk("abort_busy", md_busy, 0);
        chk("abort_done", md_done, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("abort_no_done", md_done, 0);
        end

`ifdef HAZARD_PERF_EN
        rst_i = 1;
        tick;
        rst_i = 0;
        #1;
        chk("perf_reset", stall_cnt, 0);
        idex_memread = 1; idex_rt = 5; ifid_rs = 5;
        tick; tick; tick;
        idex_memread = 0;
        #1;
        chk("perf_three", stall_cnt, 3);
        rst_i = 1;
        tick;
        rst_i = 0;
        chk("perf_rst_again", stall_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
